// File: rtl/goertzel_bin_scheduler_if.sv
// rtl/goertzel_bin_scheduler_if.sv - Goertzel manager handshake and coefficient config bus
interface goertzel_bin_scheduler_if #(
    parameter int BIN_BITS = 2
);
    logic                request_trig;
    logic [15:0]         goertzel_mag;
    logic                mag_rdy;
    logic signed [15:0]  sin_out;
    logic signed [15:0]  cos_out;
    logic                cfg_we;
    logic [BIN_BITS-1:0] cfg_addr;
    logic signed [15:0]  cfg_sin;
    logic signed [15:0]  cfg_cos;

    modport master (
        output request_trig, goertzel_mag, mag_rdy,
        output cfg_we, cfg_addr, cfg_sin, cfg_cos,
        input  sin_out, cos_out
    );

    modport slave (
        input  request_trig, goertzel_mag, mag_rdy,
        input  cfg_we, cfg_addr, cfg_sin, cfg_cos,
        output sin_out, cos_out
    );
endinterface

// File: rtl/goertzel_bin_scheduler.sv
// rtl/goertzel_bin_scheduler.sv - per-bin coefficient server, result file and sweep peak tracker
module goertzel_bin_scheduler #(
    parameter int          NUM_BINS       = 4,
    parameter int          BIN_BITS       = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [BIN_BITS-1:0] cfg_last_bin,
    input  logic [15:0]         threshold,
    input  logic [BIN_BITS-1:0] res_addr,
    output logic [15:0]         res_mag,
    output logic [BIN_BITS-1:0] cur_bin,
    output logic                sweep_done,
    output logic [BIN_BITS-1:0] peak_bin,
    output logic [15:0]         peak_mag,
    output logic                detect,
    output logic                timeout_err,
    goertzel_bin_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        BUSY   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [15:0]  sin_tab [NUM_BINS];
    logic signed [15:0]  cos_tab [NUM_BINS];
    logic [15:0]         res_mem [NUM_BINS];

    logic signed [15:0]  sin_q;
    logic signed [15:0]  cos_q;
    logic                trig_q;
    logic                trig_rise;
    logic [15:0]         wdog_q;
    logic                wdog_expired;
    logic [15:0]         mag_q;
    logic [BIN_BITS-1:0] last_q;
    logic [15:0]         run_mag;
    logic [BIN_BITS-1:0] run_bin;
    logic [15:0]         upd_mag;
    logic [BIN_BITS-1:0] upd_bin;

    logic [BIN_BITS-1:0] cur_bin_d;
    logic                start_sweep;
    logic                start_bin;
    logic                store_mag;
    logic                fire_timeout;
    logic                count_wdog;
    logic                end_sweep;
    logic                load_coef;

    assign trig_rise    = bus.request_trig & ~trig_q;
    assign wdog_expired = (wdog_q >= (TIMEOUT_CYCLES - 16'd1));
    assign bus.sin_out  = sin_q;
    assign bus.cos_out  = cos_q;

    // Coefficients are frozen from the trigger edge until the bin's result has been accepted
    assign load_coef = (state_q != BUSY) && (state_d != BUSY);

    // Running maximum including the bin in UPDATE; strict compare keeps the lower index on ties
    always_comb begin
        upd_mag = run_mag;
        upd_bin = run_bin;
        if (mag_q > run_mag) begin
            upd_mag = mag_q;
            upd_bin = cur_bin;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_d      = state_q;
        cur_bin_d    = cur_bin;
        start_sweep  = 1'b0;
        start_bin    = 1'b0;
        store_mag    = 1'b0;
        fire_timeout = 1'b0;
        count_wdog   = 1'b0;
        end_sweep    = 1'b0;
        case (state_q)
            IDLE: begin
                cur_bin_d = '0;
                if (enable) begin
                    state_d     = ARMED;
                    start_sweep = 1'b1;
                end
            end
            ARMED: begin
                if (trig_rise) begin
                    state_d   = BUSY;
                    start_bin = 1'b1;
                end else if (!enable) begin
                    state_d   = IDLE;
                    cur_bin_d = '0;
                end
            end
            BUSY: begin
                if (bus.mag_rdy) begin
                    state_d   = UPDATE;
                    store_mag = 1'b1;
                end else if (wdog_expired) begin
                    state_d      = ARMED;
                    fire_timeout = 1'b1;
                end else begin
                    count_wdog = 1'b1;
                end
            end
            UPDATE: begin
                if (cur_bin == last_q) begin
                    end_sweep = 1'b1;
                    cur_bin_d = '0;
                end else begin
                    cur_bin_d = cur_bin + BIN_BITS'(1);
                end
                if (enable) begin
                    state_d = ARMED;
                end else begin
                    state_d   = IDLE;
                    cur_bin_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                cur_bin_d = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Coefficient table: host writes land at the next edge regardless of state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                sin_tab[i] <= '0;
                cos_tab[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            sin_tab[bus.cfg_addr] <= bus.cfg_sin;
            cos_tab[bus.cfg_addr] <= bus.cfg_cos;
        end
    end

    // Result file write on accepted magnitude, registered read port for the host
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                res_mem[i] <= '0;
            end
            res_mag <= '0;
        end else begin
            if (store_mag) begin
                res_mem[cur_bin] <= bus.goertzel_mag;
            end
            res_mag <= res_mem[res_addr];
        end
    end

    // Coefficient output register, pre-loaded with the bin that will be served next
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sin_q <= '0;
            cos_q <= '0;
        end else if (load_coef) begin
            sin_q <= sin_tab[cur_bin_d];
            cos_q <= cos_tab[cur_bin_d];
        end
    end

    // Trigger edge history, bin pointer, watchdog and error flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            trig_q      <= 1'b0;
            cur_bin     <= '0;
            wdog_q      <= '0;
            mag_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            trig_q  <= bus.request_trig;
            cur_bin <= cur_bin_d;
            if (start_bin) begin
                wdog_q <= '0;
            end else if (count_wdog && (wdog_q != 16'hFFFF)) begin
                wdog_q <= wdog_q + 16'd1;
            end
            if (store_mag) begin
                mag_q <= bus.goertzel_mag;
            end
            if (fire_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Sweep bookkeeping: running peak, published peak/detect and the done pulse
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_q     <= '0;
            run_mag    <= '0;
            run_bin    <= '0;
            peak_mag   <= '0;
            peak_bin   <= '0;
            detect     <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= end_sweep;
            if (start_sweep) begin
                last_q  <= cfg_last_bin;
                run_mag <= '0;
                run_bin <= '0;
            end else if (state_q == UPDATE) begin
                if (end_sweep) begin
                    peak_mag <= upd_mag;
                    peak_bin <= upd_bin;
                    detect   <= (upd_mag >= threshold);
                    run_mag  <= '0;
                    run_bin  <= '0;
                    last_q   <= cfg_last_bin;
                end else begin
                    run_mag <= upd_mag;
                    run_bin <= upd_bin;
                end
            end
        end
    end

endmodule

// File: doc/goertzel_bin_scheduler.md
# goertzel_bin_scheduler

Sequences the Goertzel magnitude datapath across a programmable list of frequency bins. On each per-bank `request_trig` it serves the sin/cos coefficient pair of the current bin. It stores each returned `goertzel_mag` into a per-bin result file and tracks the sweep peak against a threshold. It sits between the host/config logic and the Goertzel manager, replacing hard-wired coefficients.

## Interface
- `NUM_BINS`, 4: coefficient/result entries (power of two).
- `BIN_BITS`, 2: log2(NUM_BINS).
- `TIMEOUT_CYCLES`, 16'hFFFF: max cycles from trig accept to `mag_rdy`.

- `sys_clk` in 1: system clock. One clock domain.
- `sys_rst` in 1: synchronous, active-high reset.
- `enable` in 1: run sweeps continuously while high.
- `cfg_we` in 1: coefficient table write strobe.
- `cfg_addr` in BIN_BITS: table entry to write.
- `cfg_sin`, `cfg_cos` in 16 signed: Q2.14 coefficients to write.
- `cfg_last_bin` in BIN_BITS: index of the final active bin; sampled at sweep start.
- `threshold` in 16: detect threshold, unsigned.
- `request_trig` in 1: from the manager; a rising edge starts a bin.
- `goertzel_mag` in 16: magnitude, unsigned.
- `mag_rdy` in 1: one-cycle pulse indicating `goertzel_mag` is valid.
- `sin_out`, `cos_out` out 16 signed: coefficients driven to the manager.
- `res_addr` in BIN_BITS: result file read address.
- `res_mag` out 16: registered `result[res_addr]`, available 1 cycle after the address.
- `cur_bin` out BIN_BITS: bin currently served.
- `sweep_done` out 1: one-cycle pulse after the last active bin is stored.
- `peak_bin` out BIN_BITS, `peak_mag` out 16: sweep maximum, updated at `sweep_done`.
- `detect` out 1: `peak_mag >= threshold`, updated at `sweep_done`.
- `timeout_err` out 1: sticky; cleared only by reset.

## Operation
- The coefficient table is NUM_BINS×32 bits of registers. A `cfg_we` write takes effect at the next edge in any state.
- The result file is NUM_BINS×16 bits.
- FSM:
  - IDLE: `cur_bin`=0. Outputs track `table[0]`. `request_trig` is ignored. Goes to ARMED when `enable`=1, latching `cfg_last_bin` into `last_q` and clearing the running peak (`run_mag`=0, `run_bin`=0).
  - ARMED: `sin_out`/`cos_out` re-register `table[cur_bin]` every cycle. A rising edge of `request_trig` goes to BUSY; outputs freeze and the watchdog counter clears. If `enable`=0 and no edge is present, go to IDLE.
  - BUSY: outputs are frozen, so a cfg write to `cur_bin` is not visible until the next ARMED. The watchdog increments each cycle.
    - `mag_rdy`=1: `result[cur_bin]`←`goertzel_mag`, go to UPDATE.
    - Watchdog reaches TIMEOUT_CYCLES: set `timeout_err`, go to ARMED with `cur_bin` unchanged and no result written.
  - UPDATE (one cycle):
    - If `goertzel_mag_q > run_mag` (strict, so the lower index wins ties), update `run_mag` and `run_bin`.
    - If `cur_bin == last_q`: pulse `sweep_done`, load `peak_mag`/`peak_bin`/`detect` from the running values (including this bin), set `cur_bin`←0, clear the running peak, and re-sample `cfg_last_bin`.
    - Otherwise `cur_bin`←`cur_bin`+1.
    - Next state is ARMED if `enable`=1, else IDLE.
- `enable` falling in BUSY/UPDATE: the in-flight bin completes and is stored, then the FSM goes to IDLE. A partial sweep produces no `sweep_done`, and `peak_*` holds its previous values.
- `mag_rdy` outside BUSY: ignored.
- `cfg_last_bin` = 0: single-bin sweep, with `sweep_done` after every bin.
- Reset values: all outputs 0, FSM=IDLE, table and result file 0, `timeout_err`=0.

## Timing
- The manager samples coefficients 1 cycle after `request_trig` rises. `sin_out`/`cos_out` are always stable in ARMED, so no wait state is needed.
- A cfg write to `cur_bin` in ARMED appears on `sin_out`/`cos_out` 2 edges later (table write, then output register).
- Result path:
  - `mag_rdy` at edge N: `result[]` is written at N. The FSM is in UPDATE during N→N+1.
  - `sweep_done`, `peak_*` and `detect` are valid after edge N+1.
  - `cur_bin` advances at N+1.
- Edge detection on `request_trig` uses a registered copy. A level held high across bins triggers only once.
- The watchdog saturates and cannot wrap.

## Test plan
- Sweep 4 bins, `cfg_last_bin`=3, with mags 100, 900, 900, 50 and threshold 800 -> `result` = {100, 900, 900, 50}; `sweep_done` 1 cycle after the 4th `mag_rdy`; `peak_bin`=1 (tie goes to the lower index); `peak_mag`=900; `detect`=1.
- Write table[2] = (16'h3CC5, 16'h1413) while bin 2 is BUSY with old (16'h3F31, 16'h03EC) -> outputs stay 3F31/03EC until UPDATE; next sweep's bin 2 serves 3CC5/1413.
- No `mag_rdy` with TIMEOUT_CYCLES=16 -> `timeout_err`=1 after exactly 16 BUSY cycles; `cur_bin` unchanged; next trig retries the same bin.
- Drop `enable` while BUSY on bin 1 -> bin 1 mag is stored, FSM goes to IDLE, `cur_bin`=0, no `sweep_done`, `peak_*` unchanged.
- Assert `sys_rst` mid-BUSY -> next cycle: all outputs 0, IDLE, table cleared; stray `mag_rdy` afterwards is ignored.
- `cfg_last_bin`=0 with threshold 16'hFFFF and mag 16'hFFFE -> `sweep_done` on every bin with `detect`=0; with mag 16'hFFFF -> `detect`=1.
